spi_tx_arbiter: RTL and testbench

Shares one SPI transmit channel (cs, sclk, sdo) between several word-producing requesters, such as the free-running counter and a status/debug source. Each requester presents a word and a request. The arbiter grants one requester at a time and serializes its word through a mode-0 SPI shifter, then signals completion. It sits between the counter-style datapath blocks and the off-chip display/SPI pins, and replaces direct pin ownership by any single block.

---
 rtl/spi_arb_pkg.sv | 19 +
 rtl/spi_tx_arbiter_shifter.sv | 63 ++++++
 rtl/spi_tx_arbiter.sv | 133 +++++++++++++
 tb/tb_spi_tx_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI transmit arbiter slice.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int unsigned DEF_WIDTH  = 16;
  localparam int unsigned DEF_CLKDIV = 2;

  // Bit-counter width: enough to count 0..w-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/spi_tx_arbiter_shifter.sv
// Mode-0 SPI serializer: shift register, CLKDIV prescaler, sclk/sdo and bit count.
// The prescaler free-runs while 'run' is high so the controller can also time
// its SETUP and HOLD phases from 'tick'.
module spi_shifter
  import spi_arb_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned CLKDIV = DEF_CLKDIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             run,
  input  logic             shift_en,
  output logic             tick,
  output logic             last,
  output logic             sclk,
  output logic             sdo
);

  localparam int unsigned BW = cnt_width(WIDTH);
  localparam int unsigned DW = $clog2(CLKDIV + 1);

  logic [WIDTH-1:0] sreg;
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;

  assign tick = (div_cnt == DW'(CLKDIV - 1));
  assign last = shift_en && tick && sclk && (bit_cnt == BW'(WIDTH - 1));

  // Load the word at grant, then toggle sclk every CLKDIV cycles and shift on the falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      sdo     <= 1'b0;
    end else if (load) begin
      sreg    <= word;
      sdo     <= word[WIDTH-1];
      sclk    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (run) begin
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (shift_en && tick) begin
        if (!sclk) begin
          sclk <= 1'b1;
        end else begin
          sclk    <= 1'b0;
          sreg    <= {sreg[WIDTH-2:0], 1'b0};
          sdo     <= sreg[WIDTH-2];
          bit_cnt <= last ? '0 : bit_cnt + BW'(1);
        end
      end
    end else begin
      div_cnt <= '0;
    end
  end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Shares one SPI mode-0 transmit channel between NREQ requesters.
// Optional build macro SPI_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins)
// instead of the default round-robin.
module spi_tx_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned CLKDIV = DEF_CLKDIV
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  cs,
  output logic                  sclk,
  output logic                  sdo
);

  localparam int unsigned OW = $clog2(NREQ);

  state_t           state;
  logic [OW-1:0]    win_idx;
  logic             any_req;
  logic [WIDTH-1:0] win_word;
  logic             load;
  logic             tick;
  logic             last;

`ifndef SPI_ARB_FIXED_PRIO_EN
  logic [OW-1:0]    last_owner;
`endif

  // Pick the winning requester; iterating from the far end lets the nearest candidate win.
  always_comb begin
    win_idx = '0;
    any_req = 1'b0;
`ifdef SPI_ARB_FIXED_PRIO_EN
    for (int unsigned i = NREQ; i > 0; i--) begin
      if (req[i-1]) begin
        win_idx = OW'(i - 1);
        any_req = 1'b1;
      end
    end
`else
    for (int unsigned k = NREQ; k > 0; k--) begin
      int unsigned idx;
      idx = k + 32'(last_owner);
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[OW'(idx)]) begin
        win_idx = OW'(idx);
        any_req = 1'b1;
      end
    end
`endif
  end

  // Select the winner's word for loading into the shifter.
  always_comb begin
    win_word = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (OW'(i) == win_idx) win_word = data[i*WIDTH +: WIDTH];
    end
  end

  assign load = (state == IDLE) && enable && any_req;

  // Frame sequencing: grant, setup, shift, inter-frame hold; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= '0;
      done       <= '0;
      busy       <= 1'b0;
      cs         <= 1'b1;
`ifndef SPI_ARB_FIXED_PRIO_EN
      last_owner <= OW'(NREQ - 1);
`endif
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (load) begin
            gnt   <= NREQ'(1) << win_idx;
            busy  <= 1'b1;
            cs    <= 1'b0;
            state <= SETUP;
`ifndef SPI_ARB_FIXED_PRIO_EN
            last_owner <= win_idx;
`endif
          end
        end
        SETUP: if (tick) state <= SHIFT;
        SHIFT: begin
          if (last) begin
            state <= HOLD;
            cs    <= 1'b1;
            done  <= gnt;
            gnt   <= '0;
          end
        end
        HOLD: begin
          if (tick) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  spi_shifter #(
    .WIDTH (WIDTH),
    .CLKDIV(CLKDIV)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .word    (win_word),
    .run     (state != IDLE),
    .shift_en(state == SHIFT),
    .tick    (tick),
    .last    (last),
    .sclk    (sclk),
    .sdo     (sdo)
  );

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Scoreboard bench for spi_tx_arbiter: a frame-level reference model predicts
// grants, per-cycle pin levels and transmitted words; a monitor reconstructs
// each frame from the pins and compares.
module tb_spi_tx_arbiter;

  localparam int N   = 2;
  localparam int W   = 16;
  localparam int D   = 2;
  localparam int L   = D + 2 * D * W;   // cs low cycles
  localparam int HE  = L + D;           // age at which the arbiter is idle again

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [N-1:0]     req;
  logic [W-1:0]     dw [N];
  logic [N*W-1:0]   data;
  logic [N-1:0]     gnt, done;
  logic             busy, cs, sclk, sdo;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign data[g*W +: W] = dw[g];
  end

  spi_tx_arbiter #(.NREQ(N), .WIDTH(W), .CLKDIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .data(data),
    .gnt(gnt), .done(done), .busy(busy), .cs(cs), .sclk(sclk), .sdo(sdo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int idx; logic [W-1:0] word; } frame_t;
  frame_t     exp_q[$];
  bit         m_active = 1'b0;
  int         m_age = 0;
  int         m_owner = 0;
  int         m_ptr = N - 1;

  function automatic int pick(input logic [N-1:0] r, input int ptr);
`ifdef SPI_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
`endif
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_age    = 0;
      m_ptr    = N - 1;
      exp_q.delete();
    end else if (m_active) begin
      m_age++;
      if (m_age == HE) m_active = 1'b0;
    end else if (enable && req != '0) begin
      int w;
      w        = pick(req, m_ptr);
      m_owner  = w;
      m_ptr    = w;
      m_active = 1'b1;
      m_age    = 0;
      exp_q.push_back('{idx: w, word: dw[w]});
    end
  end

  // ---------------- monitor ----------------
  bit         prev_cs = 1'b1;
  bit         prev_sclk = 1'b0;
  bit         in_frame = 1'b0;
  int         nbits, low_cnt;
  logic [W-1:0] shw;
  logic [N-1:0] cap_gnt;
  logic [W-1:0] log_q[$];

  always @(negedge clk) begin
    logic       framing;
    logic [N-1:0] oh;
    framing = m_active && (m_age < L);
    oh = N'(1) << m_owner;
    check("cs",   32'(cs),   32'(!framing));
    check("gnt",  32'(gnt),  framing ? 32'(oh) : 32'd0);
    check("done", 32'(done), (m_active && m_age == L) ? 32'(oh) : 32'd0);
    check("busy", 32'(busy), 32'(m_active));
    check("sclk", 32'(sclk),
          32'(framing && m_age >= D && ((m_age - D) % (2 * D)) >= D));
    if (!rst_n) begin
      in_frame = 1'b0;
    end else begin
      if (prev_cs && !cs) begin
        in_frame = 1'b1;
        nbits    = 0;
        low_cnt  = 0;
        shw      = '0;
        cap_gnt  = gnt;
      end
      if (in_frame && !cs) low_cnt++;
      if (in_frame && !prev_sclk && sclk) begin
        shw = {shw[W-2:0], sdo};
        nbits++;
      end
      if (in_frame && !prev_cs && cs) begin
        in_frame = 1'b0;
        log_q.push_back(shw);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_frame actual=%0h required=none", shw);
        end else begin
          frame_t e;
          e = exp_q.pop_front();
          check("sb_owner", 32'(cap_gnt), 32'(N'(1) << e.idx));
          check("sb_word",  32'(shw),     32'(e.word));
          check("sb_bits",  32'(nbits),   32'(W));
          check("sb_cs_low", 32'(low_cnt), 32'(L));
          check("sb_done",  32'(done),    32'(N'(1) << e.idx));
        end
      end
    end
    prev_cs   = cs;
    prev_sclk = sclk;
  end

  // ---------------- stimulus ----------------
  task automatic wait_done(input int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done[i] && n < 300);
    checks++;
    if (!done[i]) begin
      errors++;
      $display("FAIL wait_done%0d actual=timeout required=pulse", i);
    end
  endtask

  task automatic wait_any_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == '0 && n < 300);
    check("wait_any_done", 32'(done != '0), 32'd1);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int lowseen;
    logic [W-1:0] exp4 [4];
    rst_n  = 1'b0;
    enable = 1'b1;
    req    = '0;
    for (int i = 0; i < N; i++) dw[i] = '0;

    // Reset values, then idle with nothing requested
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_sdo", 32'(sdo), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_cs", 32'(cs), 32'd1);

    // Single request
    dw[0] = 16'hA5C3;
    req   = 2'b01;
    @(negedge clk);
    check("gnt_latency", 32'(gnt), 32'd1);
    wait_done(0);
    req = '0;
    repeat (4) @(negedge clk);
    check("single_word", 32'(log_q[log_q.size()-1]), 32'hA5C3);

    // Contention from a fresh reset
    reset_pulse();
    s0    = log_q.size();
    dw[0] = 16'h1234;
    dw[1] = 16'hFFFF;
    req   = 2'b11;
    for (int f = 0; f < 4; f++) wait_any_done();
    req = '0;
    repeat (10) @(negedge clk);
`ifdef SPI_ARB_FIXED_PRIO_EN
    exp4 = '{16'h1234, 16'h1234, 16'h1234, 16'h1234};
`else
    exp4 = '{16'h1234, 16'hFFFF, 16'h1234, 16'hFFFF};
`endif
    check("cont_count", 32'(log_q.size() - s0), 32'd4);
    for (int f = 0; f < 4; f++)
      if (s0 + f < log_q.size()) check("cont_order", 32'(log_q[s0+f]), 32'(exp4[f]));

    // Enable dropped mid-frame
    dw[0] = 16'h5A0F;
    req   = 2'b01;
    repeat (40) @(negedge clk);
    enable = 1'b0;
    wait_done(0);
    lowseen = 0;
    repeat (100) begin
      @(negedge clk);
      if (!cs) lowseen++;
    end
    check("en_low_no_cs", 32'(lowseen), 32'd0);
    enable = 1'b1;
    @(negedge clk);
    check("en_regrant", 32'(gnt), 32'd1);
    wait_done(0);
    req = '0;
    repeat (5) @(negedge clk);

    // Reset during bit 5 of a frame
    dw[0] = 16'hC001;
    dw[1] = 16'h0BAD;
    req   = 2'b11;
    @(negedge clk);
    repeat (D + 5 * 2 * D) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_cs", 32'(cs), 32'd1);
    check("mrst_sclk", 32'(sclk), 32'd0);
    check("mrst_gnt", 32'(gnt), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_any_done();
    check("mrst_restart_owner", 32'(done), 32'd1);
    req[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("mrst_restart_word", 32'(log_q[log_q.size()-1]), 32'hC001);
    wait_done(1);
    req = '0;

    // Randomized traffic
    repeat (4000) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (req[i] && done[i]) req[i] = 1'b0;
        else if (!req[i]) begin
          if ($urandom_range(0, 9) == 0) begin
            req[i] = 1'b1;
            dw[i]  = W'($urandom);
          end
        end else if ($urandom_range(0, 99) == 0) req[i] = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) dw[$urandom_range(0, N-1)] = W'($urandom);
      if (enable && $urandom_range(0, 199) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
    end

    // Drain
    req    = '0;
    enable = 1'b1;
    for (int n = 0; n < 200 && busy; n++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
